ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, CLKIN cycles of clock inhibit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max CLKIN cycles from clock release to acknowledge (15 ms).
REQ-003 SHALL have port CLKIN  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port ACLR_L  input  1  asynchronous active-low reset.
REQ-005 SHALL have port TX_START  input  1  one-cycle request to send TX_DATA.
REQ-006 SHALL have port TX_DATA  input  8  command byte, sampled on the accepted TX_START cycle.
REQ-007 SHALL have port PS2_CLK_IN  input  1  raw PS/2 clock line level, asynchronous.
REQ-008 SHALL have port PS2_DAT_IN  input  1  raw PS/2 data line level, asynchronous.
REQ-009 SHALL have port PS2_CLK_OE  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-010 SHALL have port PS2_DAT_OE  output  1  1 = pull PS/2 data low; 0 = release.
REQ-011 SHALL have port BUSY  output  1  high from the cycle after accepted TX_START until the return to IDLE.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse: byte acknowledged, bus idle.
REQ-013 SHALL have port ERR  output  1  one-cycle pulse: timeout or missing acknowledge.

Function
REQ-014 SHALL pass PS2_CLK_IN and PS2_DAT_IN through two-flop synchronizers; falling edge = previous synchronized clock 1, current 0.
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: TX_START=1 latches TX_DATA, computes odd parity (parity bit = ~^TX_DATA), enters INHIBIT; TX_START in any other state is ignored.
REQ-017 INHIBIT: PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-018 REQ: PS2_DAT_OE=1 (start bit) and PS2_CLK_OE=0 in the same cycle; timeout counter clears; enter SEND.
REQ-019 SEND: on each device falling edge, present next bit via PS2_DAT_OE = ~bit, LSB first: D0..D7, parity, stop (stop = release, PS2_DAT_OE=0); 10 edges total, bit index 0..9.
REQ-020 After the 10th falling edge SHALL enter ACK; on the next falling edge sample synchronized data: 0 -> WAIT_IDLE, 1 -> ERR pulse, IDLE.
REQ-021 WAIT_IDLE: when synchronized clock and data both 1, pulse DONE for one cycle and enter IDLE.
REQ-022 Timeout counter SHALL run in SEND, ACK, WAIT_IDLE; reaching TIMEOUT_CYCLES -> ERR pulse, both OE released the same cycle, IDLE.
REQ-023 DONE and ERR SHALL be mutually exclusive and never asserted in IDLE except on the transition cycle.
REQ-024 PS2_CLK_OE SHALL be 1 only in INHIBIT; PS2_DAT_OE SHALL be 0 in IDLE, INHIBIT, ACK, WAIT_IDLE.
REQ-025 Counters SHALL saturate-free wrap only by explicit clear; inhibit counter width ceil(log2(INHIBIT_CYCLES+1)), timeout width ceil(log2(TIMEOUT_CYCLES+1)).

Reset
REQ-026 ACLR_L=0 SHALL asynchronously force IDLE, PS2_CLK_OE=0, PS2_DAT_OE=0, BUSY=0, DONE=0, ERR=0, counters and bit index 0, synchronizers to 1.
REQ-027 Reset mid-transfer SHALL release both lines immediately and produce no DONE/ERR pulse.

Structure
REQ-028 State encoding, default INHIBIT_CYCLES/TIMEOUT_CYCLES, and bit-count constant (10) SHALL live in shared package ps2_pkg used by the receiver.
REQ-029 Synchronizer plus falling-edge detector SHALL be sub-module ps2_sync_edge, shared with the receiver.

Verification (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000)
REQ-030 TX_DATA=0xED, device model clocks 11 falling edges, ACK low -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; DONE one pulse; PS2_CLK_OE high exactly 10 cycles.
REQ-031 TX_DATA=0x01 -> parity bit 0; TX_DATA=0xFF -> parity bit 1; both DONE.
REQ-032 Device never clocks -> ERR pulse 2000 cycles after REQ, both OE 0, BUSY 0, no DONE.
REQ-033 Device clocks 11 edges but leaves data high at ACK -> ERR pulse, IDLE.
REQ-034 TX_START pulsed again during SEND with TX_DATA=0x55 -> ignored; original byte completes, single DONE.
REQ-035 ACLR_L low during bit 4 of SEND -> OE lines 0 at once, no DONE/ERR; next TX_START=0xF4 completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the receiver:
// FSM state encoding, default timing constants and the frame length.
package ps2_pkg;

    // 100 us of clock inhibit at 50 MHz.
    localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
    // 15 ms from clock release to acknowledge at 50 MHz.
    localparam int PS2_TIMEOUT_CYCLES_DEF = 750000;
    // Bits clocked by the device after the start bit: D0..D7, parity, stop.
    localparam int PS2_FRAME_BITS         = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock.
module ps2_sync_edge (
    input  logic CLKIN,
    input  logic ACLR_L,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic dat_meta_q, dat_meta_d;
    logic dat_sync_q, dat_sync_d;

    // Next values: shift each line through its synchronizer chain.
    always_comb begin
        clk_meta_d = ps2_clk_in;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_dat_in;
        dat_sync_d = dat_meta_q;
    end

    // Synchronizer registers; idle bus level (high) on reset.
    always_ff @(posedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    assign clk_sync = clk_sync_q;
    assign dat_sync = dat_sync_q;
    assign clk_fall = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues the
// request-to-send, shifts out one byte with odd parity on the device's
// clock, checks the acknowledge and waits for the bus to go idle.
// Line drivers are open-drain enables: OE=1 pulls the line low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic       CLKIN,
    input  logic       ACLR_L,
    input  logic       TX_START,
    input  logic [7:0] TX_DATA,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DAT_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       idx_q, idx_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_sync, dat_sync, clk_fall;
    logic in_xfer;
    logic tmo_hit;

    ps2_sync_edge u_sync (
        .CLKIN      (CLKIN),
        .ACLR_L     (ACLR_L),
        .ps2_clk_in (PS2_CLK_IN),
        .ps2_dat_in (PS2_DAT_IN),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .clk_fall   (clk_fall)
    );

    // Frame bit presented after the falling edge with index idx:
    // D0..D7, then parity, then stop (line released).
    function automatic logic frame_bit(input logic [7:0] d, input logic p,
                                       input logic [3:0] idx);
        if (idx < 4'd8)       return d[idx[2:0]];
        else if (idx == 4'd8) return p;
        else                  return 1'b1;
    endfunction

    // The device must complete the whole frame, ack and bus release within
    // TIMEOUT_CYCLES cycles of the clock release.
    assign in_xfer = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
    assign tmo_hit = in_xfer && (tmo_q == TMO_LAST);

    // Next-state and registered line/pulse outputs; outputs are computed
    // for the state being entered so they change together with it.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        inh_d    = inh_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                inh_d = '0;
                idx_d = '0;
                if (TX_START) begin
                    data_d   = TX_DATA;
                    par_d    = odd_parity(TX_DATA);
                    state_d  = INHIBIT;
                    clk_oe_d = 1'b1;
                end
            end
            INHIBIT: begin
                clk_oe_d = 1'b1;
                inh_d    = inh_q + 1'b1;
                if (inh_q == INH_LAST) begin
                    // Release clock and pull data (start bit) together.
                    state_d  = REQ;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    inh_d    = '0;
                end
            end
            REQ: begin
                tmo_d    = '0;
                idx_d    = '0;
                dat_oe_d = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                tmo_d    = tmo_q + 1'b1;
                dat_oe_d = dat_oe_q;
                if (clk_fall) begin
                    dat_oe_d = ~frame_bit(data_q, par_q, idx_q);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ACK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ACK: begin
                tmo_d = tmo_q + 1'b1;
                if (clk_fall) begin
                    if (dat_sync) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                tmo_d = tmo_q + 1'b1;
                if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout aborts the transfer unless it completed this same cycle.
        if (tmo_hit && !done_d && !err_d) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
        end
    end

    // State, counters and registered outputs; reset releases both lines.
    always_ff @(posedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            inh_q    <= '0;
            tmo_q    <= '0;
            idx_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            inh_q    <= inh_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign PS2_CLK_OE = clk_oe_q;
    assign PS2_DAT_OE = dat_oe_q;
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain bus and PS/2
// device model.
module tb_ps2_host_tx;

    logic       CLKIN = 1'b0;
    logic       ACLR_L = 1'b0;
    logic       TX_START = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       PS2_CLK_IN, PS2_DAT_IN;
    logic       PS2_CLK_OE, PS2_DAT_OE, BUSY, DONE, ERR;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int tests = 0;
    int fails = 0;
    int n_done = 0, n_err = 0, n_clkoe = 0, n_both = 0;

    // Open-drain bus with pull-ups.
    assign PS2_CLK_IN = ~(PS2_CLK_OE | dev_clk_low);
    assign PS2_DAT_IN = ~(PS2_DAT_OE | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(2000)) dut (
        .CLKIN      (CLKIN),
        .ACLR_L     (ACLR_L),
        .TX_START   (TX_START),
        .TX_DATA    (TX_DATA),
        .PS2_CLK_IN (PS2_CLK_IN),
        .PS2_DAT_IN (PS2_DAT_IN),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DAT_OE (PS2_DAT_OE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLKIN = ~CLKIN;

    // Cycle-level event counters, sampled just after each rising edge.
    always begin
        @(posedge CLKIN);
        #1;
        if (DONE) n_done++;
        if (ERR) n_err++;
        if (PS2_CLK_OE) n_clkoe++;
        if (DONE && ERR) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLKIN);
    endtask

    task automatic start_tx(input logic [7:0] d);
        TX_DATA  = d;
        TX_START = 1'b1;
        tick(1);
        TX_START = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int w = 0; w < 300 && BUSY; w++) tick(1);
        check(tag, BUSY, 1'b0);
    endtask

    // Device: wait for request-to-send, then clock `edges` falling edges,
    // sampling the data line on each rising edge. Optionally acks, pokes a
    // second TX_START at edge poke_edge, or resets the DUT at abort_edge.
    task automatic device(input int edges, input bit ack_low, input int poke_edge,
                          input int abort_edge, output logic [9:0] bits, output bit ok);
        bits = '0;
        ok   = 1'b0;
        for (int w = 0; w < 100 && !(PS2_DAT_OE && !PS2_CLK_OE); w++) tick(1);
        if (!(PS2_DAT_OE && !PS2_CLK_OE)) return;
        ok = 1'b1;
        tick(4);
        for (int i = 0; i < edges; i++) begin
            if (i == 10 && ack_low) begin
                dev_dat_low = 1'b1;
                tick(2);
            end
            dev_clk_low = 1'b1;
            if (i == poke_edge) begin
                tick(1);
                TX_DATA  = 8'h55;
                TX_START = 1'b1;
                tick(1);
                TX_START = 1'b0;
                tick(6);
            end else if (i == abort_edge) begin
                tick(4);
                check("abort_dat_oe_before", PS2_DAT_OE, 1'b1);
                #2 ACLR_L = 1'b0;
                #1;
                check("abort_clk_oe", PS2_CLK_OE, 1'b0);
                check("abort_dat_oe", PS2_DAT_OE, 1'b0);
                check("abort_busy", BUSY, 1'b0);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                return;
            end else begin
                tick(8);
            end
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = PS2_DAT_IN;
            tick(8);
        end
        dev_dat_low = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        bit         ok;
        int         d0, e0, c0, n;

        // Reset state
        ACLR_L = 1'b0;
        tick(3);
        check("rst_clk_oe", PS2_CLK_OE, 1'b0);
        check("rst_dat_oe", PS2_DAT_OE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_err", ERR, 1'b0);
        ACLR_L = 1'b1;
        tick(2);

        // 0xED: D=1,0,1,1,0,1,1,1 parity 1 stop 1 -> frame 0x3ED
        d0 = n_done; e0 = n_err; c0 = n_clkoe;
        check("ed_busy_pre", BUSY, 1'b0);
        start_tx(8'hED);
        check("ed_busy", BUSY, 1'b1);
        device(11, 1'b1, -1, -1, bits, ok);
        check("ed_req", ok, 1'b1);
        check("ed_frame", bits, 10'h3ED);
        wait_idle("ed_idle");
        check("ed_done_cnt", n_done - d0, 1);
        check("ed_err_cnt", n_err - e0, 0);
        check("ed_clk_oe_cycles", n_clkoe - c0, 10);

        // 0x01: parity 0 -> frame 0x201
        d0 = n_done;
        start_tx(8'h01);
        device(11, 1'b1, -1, -1, bits, ok);
        check("x01_frame", bits, 10'h201);
        wait_idle("x01_idle");
        check("x01_done_cnt", n_done - d0, 1);

        // 0xFF: parity 1 -> frame 0x3FF
        d0 = n_done;
        start_tx(8'hFF);
        device(11, 1'b1, -1, -1, bits, ok);
        check("xff_frame", bits, 10'h3FF);
        wait_idle("xff_idle");
        check("xff_done_cnt", n_done - d0, 1);

        // Device never clocks: ERR after the 2000-cycle window following REQ
        d0 = n_done; e0 = n_err;
        start_tx(8'h3C);
        for (int w = 0; w < 100 && !PS2_DAT_OE; w++) tick(1);
        check("tmo_req", PS2_DAT_OE, 1'b1);
        n = 0;
        while (!ERR && n < 3000) begin
            tick(1);
            n++;
        end
        check("tmo_latency", n, 2001);
        check("tmo_clk_oe", PS2_CLK_OE, 1'b0);
        check("tmo_dat_oe", PS2_DAT_OE, 1'b0);
        check("tmo_busy", BUSY, 1'b0);
        tick(1);
        check("tmo_err_pulse", ERR, 1'b0);
        check("tmo_err_cnt", n_err - e0, 1);
        check("tmo_done_cnt", n_done - d0, 0);

        // Full frame but no acknowledge -> ERR
        d0 = n_done; e0 = n_err;
        start_tx(8'h3C);
        device(11, 1'b0, -1, -1, bits, ok);
        check("nack_frame", bits, 10'h33C);
        wait_idle("nack_idle");
        check("nack_err_cnt", n_err - e0, 1);
        check("nack_done_cnt", n_done - d0, 0);

        // Second TX_START (0x55) during SEND is ignored
        d0 = n_done; e0 = n_err;
        start_tx(8'h3C);
        device(11, 1'b1, 3, -1, bits, ok);
        check("poke_frame", bits, 10'h33C);
        wait_idle("poke_idle");
        tick(20);
        check("poke_no_restart", BUSY, 1'b0);
        check("poke_done_cnt", n_done - d0, 1);
        check("poke_err_cnt", n_err - e0, 0);

        // Reset during bit 4, then a normal 0xF4 transfer (parity 0 -> 0x2F4)
        d0 = n_done; e0 = n_err;
        start_tx(8'hA5);
        device(11, 1'b1, -1, 4, bits, ok);
        tick(3);
        ACLR_L = 1'b1;
        tick(3);
        check("abort_done_cnt", n_done - d0, 0);
        check("abort_err_cnt", n_err - e0, 0);
        start_tx(8'hF4);
        device(11, 1'b1, -1, -1, bits, ok);
        check("f4_frame", bits, 10'h2F4);
        wait_idle("f4_idle");
        check("f4_done_cnt", n_done - d0, 1);
        check("f4_err_cnt", n_err - e0, 0);

        check("done_err_exclusive", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
